// File: rtl/dpad_pkg.sv
// Shared definitions for the d-pad conditioner: direction indices,
// auto-repeat FSM states and the arbitration priority order.
package dpad_pkg;

    localparam int NUM_DIRS = 4;

    typedef logic [1:0] dir_idx_t;

    localparam dir_idx_t DIR_LEFT  = 2'd0;
    localparam dir_idx_t DIR_DOWN  = 2'd1;
    localparam dir_idx_t DIR_UP    = 2'd2;
    localparam dir_idx_t DIR_RIGHT = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT,
        LOCKOUT
    } rpt_state_t;

    // Highest priority first.
    localparam dir_idx_t PRIORITY_ORDER [NUM_DIRS] = '{DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT};

    function automatic int cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dpad_conditioner_debounce_cell.sv
// One button: 2-FF synchronizer, optional inversion, and a debounce counter
// that only lets a level change through after DEBOUNCE_CYCLES stable cycles.
module debounce_cell
    import dpad_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 125000,
    parameter bit          ACTIVE_LOW      = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level
);

    localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic          s;

    assign s = sync[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            sync  <= '0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout so every flop samples
            // the pre-edge value; blocking here would collapse the sync chain.
            sync <= {sync[0], raw ^ ACTIVE_LOW};
            if (s == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= ~level;
                cnt   <= '0;
            end else if (cnt != '1) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/dpad_conditioner.sv
// D-pad conditioner: four debounce cells feeding per-button press/auto-repeat
// FSMs, with a fixed-priority arbiter producing registered one-hot move pulses.
module dpad_conditioner
    import dpad_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 125000,
    parameter int unsigned REPEAT_DELAY    = 6250000,
    parameter int unsigned REPEAT_PERIOD   = 2500000,
    parameter bit          REPEAT_EN       = 1'b1,
    parameter bit          ACTIVE_LOW      = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_DIRS-1:0] button_raw,
    input  logic                enable,
    output logic [NUM_DIRS-1:0] dpad_level,
    output logic [NUM_DIRS-1:0] dpad_pulse
);

    localparam int RW_DELAY  = cnt_width(REPEAT_DELAY);
    localparam int RW_PERIOD = cnt_width(REPEAT_PERIOD);
    localparam int RW        = (RW_DELAY > RW_PERIOD) ? RW_DELAY : RW_PERIOD;

    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

    rpt_state_t          state   [NUM_DIRS];
    logic [RW-1:0]       rpt_cnt [NUM_DIRS];
    logic [NUM_DIRS-1:0] req;
    logic [NUM_DIRS-1:0] grant;
    logic [NUM_DIRS-1:0] pulse_q;
    logic                found;

    for (genvar gi = 0; gi < NUM_DIRS; gi++) begin : g_cell
        debounce_cell #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .ACTIVE_LOW     (ACTIVE_LOW)
        ) u_cell (
            .clk  (clk),
            .reset(reset),
            .raw  (button_raw[gi]),
            .level(dpad_level[gi])
        );
    end

    always_comb begin
        // NOTE: default every output first so no path leaves req holding a
        // stale value, which would infer a latch.
        req = '0;
        for (int i = 0; i < NUM_DIRS; i++) begin
            if (dpad_level[i] && enable) begin
                case (state[i])
                    IDLE:    req[i] = 1'b1;
                    DELAY:   req[i] = REPEAT_EN && (rpt_cnt[i] == DELAY_LAST);
                    REPEAT:  req[i] = (rpt_cnt[i] == PERIOD_LAST);
                    default: req[i] = 1'b0;
                endcase
            end
        end
    end

    // Losing requests are dropped; their FSMs advance regardless.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int p = 0; p < NUM_DIRS; p++) begin
            if (!found && req[PRIORITY_ORDER[p]]) begin
                grant[PRIORITY_ORDER[p]] = 1'b1;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pulse_q <= '0;
            // NOTE: these are four small per-button registers, not a RAM, so
            // resetting the whole array is cheap and keeps the FSMs defined.
            for (int i = 0; i < NUM_DIRS; i++) begin
                state[i]   <= IDLE;
                rpt_cnt[i] <= '0;
            end
        end else begin
            pulse_q <= grant;
            for (int i = 0; i < NUM_DIRS; i++) begin
                if (!dpad_level[i]) begin
                    state[i]   <= IDLE;
                    rpt_cnt[i] <= '0;
                end else begin
                    case (state[i])
                        IDLE: begin
                            rpt_cnt[i] <= '0;
                            state[i]   <= enable ? DELAY : LOCKOUT;
                        end
                        DELAY: begin
                            if (!enable) begin
                                state[i] <= LOCKOUT;
                            end else if (REPEAT_EN) begin
                                if (rpt_cnt[i] == DELAY_LAST) begin
                                    rpt_cnt[i] <= '0;
                                    state[i]   <= REPEAT;
                                end else if (rpt_cnt[i] != '1) begin
                                    rpt_cnt[i] <= rpt_cnt[i] + 1'b1;
                                end
                            end
                        end
                        REPEAT: begin
                            if (!enable) begin
                                state[i] <= LOCKOUT;
                            end else if (rpt_cnt[i] == PERIOD_LAST) begin
                                rpt_cnt[i] <= '0;
                            end else if (rpt_cnt[i] != '1) begin
                                rpt_cnt[i] <= rpt_cnt[i] + 1'b1;
                            end
                        end
                        LOCKOUT: state[i] <= LOCKOUT;
                        default: state[i] <= IDLE;
                    endcase
                end
            end
        end
    end

    // A pulse requested just before enable drops must not leak out.
    assign dpad_pulse = pulse_q & {NUM_DIRS{enable}};

endmodule

// File: doc/dpad_conditioner.md
Name: dpad_conditioner

Overview:
Conditions the four raw d-pad buttons before they reach the frog movement logic. Per button it provides a 2-FF synchronizer, a debouncer, and a press/auto-repeat FSM. It emits single-cycle, one-hot move pulses plus debounced levels. It sits between the button pins and the frog block's dpad_input, replacing the direct pin-to-vector concatenation, and runs on the 25.1 MHz pixel clock.

Parameters:
DEBOUNCE_CYCLES, 125000, consecutive synchronized-stable cycles needed to change a debounced level (about 5 ms)
REPEAT_DELAY, 6250000, cycles from the press pulse to the first repeat pulse (about 250 ms)
REPEAT_PERIOD, 2500000, cycles between later repeat pulses (about 100 ms)
REPEAT_EN, 1, 0 disables auto-repeat (press pulse only)
ACTIVE_LOW, 0, 1 inverts the raw inputs before the synchronizer

Ports:
clk  input  1  pixel clock
reset  input  1  synchronous, active-high reset
button_raw  input  4  raw pins, order {right, up, down, left} (bit3..bit0), asynchronous
enable  input  1  game accepting moves; pulses are suppressed when low
dpad_level  output  4  debounced button levels, same bit order
dpad_pulse  output  4  one-hot (or zero) move pulse, 1 cycle wide, same bit order

Behaviour:
- Reset: dpad_level=0, dpad_pulse=0, synchronizers=0, all counters=0, all FSMs in IDLE. A reset during any operation aborts it; the first pulse after reset needs a fresh debounced press.
- Sync: raw input, optionally inverted, goes through two flops to give s[i].
- Debounce, per bit:
  - Counter clears whenever s[i]==dpad_level[i].
  - Otherwise it increments.
  - When it is at DEBOUNCE_CYCLES-1 and s[i]!=level, the level toggles on that edge and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles never reaches dpad_level.
- Counter widths are $clog2 of the parameter, minimum 1. Comparisons use full-width unsigned values; counters saturate and never wrap.
- FSM per button. States: IDLE, DELAY, REPEAT, LOCKOUT.
  - IDLE: on a level rise with enable=1, request a pulse, clear the repeat counter, go to DELAY. On a level rise with enable=0, go to LOCKOUT.
  - DELAY: count cycles. At REPEAT_DELAY-1, request a pulse, clear, go to REPEAT. If REPEAT_EN=0, stay in DELAY without counting.
  - REPEAT: at REPEAT_PERIOD-1, request a pulse and clear.
  - LOCKOUT: wait for the level to fall, then go to IDLE. Holding a button while enable rises never moves the frog.
  - From any state, level=0 returns to IDLE on the next edge with no pulse.
  - From DELAY or REPEAT, enable=0 goes to LOCKOUT.
- Arbitration, when several requests fall in one cycle: the winner is chosen by priority up > down > left > right. Losing requests are dropped, not queued. Their FSMs still advance as if they had pulsed.
- dpad_pulse is registered: asserted on the edge after the request cycle. Total latency from a raw press edge to the pulse is exactly DEBOUNCE_CYCLES+3 clk edges.
- dpad_pulse is never asserted while enable=0, and is never wider than 1 cycle.
- dpad_level follows the debouncer regardless of enable.

Decomposition:
- Package dpad_pkg holds:
  - direction indices DIR_LEFT=0, DIR_DOWN=1, DIR_UP=2, DIR_RIGHT=3
  - the rpt_state_t enum {IDLE, DELAY, REPEAT, LOCKOUT}
  - the priority order as a constant array
- Sub-module debounce_cell (synchronizer, debounce counter, level output). It is instantiated four times. The FSMs and the arbiter stay in dpad_conditioner.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8, enable=1 unless stated otherwise.
1. up rises at cycle 0 and is held 15 cycles -> dpad_level[2]=1 from cycle 6; dpad_pulse=4'b0100 at cycle 7 only; no other pulse.
2. up held 60 cycles -> pulses at cycles 7, 27, 35, 43, 51, 59; release -> no further pulses, FSM back in IDLE.
3. left glitches high for 3 cycles, then stays low -> dpad_level and dpad_pulse remain 0 throughout.
4. up and right pressed in the same cycle and held -> only 4'b0100 at cycle 7; later repeats are also up-only; dpad_level=4'b1100.
5. enable=0 while down is pressed, enable goes to 1 at cycle 10 with down still held -> no pulse; release, then re-press -> pulse 4'b0010 DEBOUNCE_CYCLES+3 edges after the re-press.
6. reset asserted for 1 cycle during REPEAT with the button still held -> outputs 0 the next cycle; then one pulse 7 cycles after reset deasserts (button still held, treated as a fresh press).
